// File: rtl/screen_sequencer_pkg.sv
// rtl/screen_sequencer_pkg.sv - shared constants and types for the screen sequencer
//
// Purpose: screen indices, GAP length, watchdog limit and pixel field widths
//          shared by the interface, the pixel mux and the sequencer top.
// Ports:   none (package).
package screen_sequencer_pkg;

    typedef enum logic [1:0] {
        TITLE = 2'd0,
        PLAY  = 2'd1,
        WIN   = 2'd2,
        LOSE  = 2'd3
    } screen_e;

    localparam int NUM_SCREENS = 4;
    localparam int GAP_CYCLES  = 2;
    localparam int WDOG_MAX    = 255;

    localparam int X_W = 9;
    localparam int Y_W = 8;
    localparam int C_W = 3;

    localparam logic [1:0] GAP_INIT     = 2'(GAP_CYCLES);
    localparam logic [7:0] WDOG_MAX_VAL = 8'(WDOG_MAX);

    // One-hot "run" vector for a screen.
    function automatic logic [NUM_SCREENS-1:0] screen_onehot(input screen_e s);
        return 4'b0001 << s;
    endfunction

endpackage

// File: rtl/screen_sequencer_if.sv
// rtl/screen_sequencer_if.sv - pixel source/sink bus between screens, sequencer and VGA adapter
//
// Purpose: groups the four packed screen pixel sources and the registered
//          pixel stream that goes to the VGA adapter.
// Signals: src_x/src_y/src_color/src_plot  - packed per-screen sources (screen k in slice k)
//          x_out/y_out/color_out/plot_out  - selected, registered pixel stream
// Modports: master - the sequencer (consumes sources, drives the stream)
//           slave  - screens + VGA side (drives sources, consumes the stream)
interface screen_sequencer_if;
    import screen_sequencer_pkg::*;

    logic [NUM_SCREENS*X_W-1:0] src_x;
    logic [NUM_SCREENS*Y_W-1:0] src_y;
    logic [NUM_SCREENS*C_W-1:0] src_color;
    logic [NUM_SCREENS-1:0]     src_plot;

    logic [X_W-1:0]             x_out;
    logic [Y_W-1:0]             y_out;
    logic [C_W-1:0]             color_out;
    logic                       plot_out;

    modport master (
        input  src_x, src_y, src_color, src_plot,
        output x_out, y_out, color_out, plot_out
    );

    modport slave (
        output src_x, src_y, src_color, src_plot,
        input  x_out, y_out, color_out, plot_out
    );

endinterface

// File: rtl/screen_sequencer_pixel_mux4.sv
// rtl/screen_sequencer_pixel_mux4.sv - registered 4:1 pixel mux with plot gate
//
// Purpose: each cycle registers the x/y/color fields of the selected source
//          and its plot strobe ANDed with plot_en_i. One cycle latency.
// Ports:   clk, reset_n          - clock, async active-low reset
//          sel_i                 - selected source index
//          plot_en_i             - gate for the plot strobe
//          src_*_i               - packed per-source fields
//          x_o/y_o/color_o/plot_o - registered selected pixel
module pixel_mux4
    import screen_sequencer_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [1:0]                 sel_i,
    input  logic                       plot_en_i,
    input  logic [NUM_SCREENS*X_W-1:0] src_x_i,
    input  logic [NUM_SCREENS*Y_W-1:0] src_y_i,
    input  logic [NUM_SCREENS*C_W-1:0] src_color_i,
    input  logic [NUM_SCREENS-1:0]     src_plot_i,
    output logic [X_W-1:0]             x_o,
    output logic [Y_W-1:0]             y_o,
    output logic [C_W-1:0]             color_o,
    output logic                       plot_o
);

    logic [X_W-1:0] xs [NUM_SCREENS];
    logic [Y_W-1:0] ys [NUM_SCREENS];
    logic [C_W-1:0] cs [NUM_SCREENS];

    logic [X_W-1:0] x_d,     x_q;
    logic [Y_W-1:0] y_d,     y_q;
    logic [C_W-1:0] color_d, color_q;
    logic           plot_d,  plot_q;

    always_comb begin
        for (int k = 0; k < NUM_SCREENS; k++) begin
            xs[k] = src_x_i[k*X_W +: X_W];
            ys[k] = src_y_i[k*Y_W +: Y_W];
            cs[k] = src_color_i[k*C_W +: C_W];
        end
        x_d     = xs[sel_i];
        y_d     = ys[sel_i];
        color_d = cs[sel_i];
        plot_d  = src_plot_i[sel_i] & plot_en_i;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x_q     <= '0;
            y_q     <= '0;
            color_q <= '0;
            plot_q  <= 1'b0;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            color_q <= color_d;
            plot_q  <= plot_d;
        end
    end

    assign x_o     = x_q;
    assign y_o     = y_q;
    assign color_o = color_q;
    assign plot_o  = plot_q;

endmodule

// File: rtl/screen_sequencer.sv
// rtl/screen_sequencer.sv - game screen sequencer: FSM, watchdog and pixel stream select
//
// Purpose: steps TITLE -> PLAY -> WIN/LOSE -> TITLE, inserts a 2-cycle GAP on
//          every screen entry, runs a frame watchdog in WIN/LOSE and forwards
//          the active screen's pixels to the VGA adapter.
// Ports:   clk, reset_n        - clock, async active-low reset
//          start               - start key level (rising edge detected here)
//          frame_tick          - 60 Hz frame pulse
//          win_evt, lose_evt   - game result pulses
//          scr_done[3:0]       - per-screen done
//          pix (master)        - pixel sources in, registered pixel stream out
//          go[3:0]             - one-hot run level to the screens
//          state_out[1:0]      - current screen index
module screen_sequencer
    import screen_sequencer_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic                   frame_tick,
    input  logic                   win_evt,
    input  logic                   lose_evt,
    input  logic [3:0]             scr_done,
    screen_sequencer_if.master     pix,
    output logic [NUM_SCREENS-1:0] go,
    output logic [1:0]             state_out
);

    screen_e                cur_q,   cur_d;
    logic [1:0]             gap_q,   gap_d;
    logic [7:0]             wdog_q,  wdog_d;
    logic                   start_q;
    logic [NUM_SCREENS-1:0] go_q,    go_d;

    logic       settled;
    logic       start_rise;
    logic       wdog_inc;
    logic [7:0] wdog_next;
    logic       wdog_expired;
    logic       entering;

    always_comb begin
        settled    = (gap_q == 2'd0);
        start_rise = start & ~start_q;

        // Watchdog only counts frames once WIN/LOSE has settled; it saturates.
        wdog_inc     = settled && ((cur_q == WIN) || (cur_q == LOSE)) && frame_tick
                       && (wdog_q != WDOG_MAX_VAL);
        wdog_next    = wdog_q + {7'd0, wdog_inc};
        // Expiry acts on the same edge as the tick that reaches the limit.
        wdog_expired = (wdog_next == WDOG_MAX_VAL);

        cur_d = cur_q;
        if (settled) begin
            unique case (cur_q)
                TITLE: if (start_rise && scr_done[0])  cur_d = PLAY;
                PLAY: begin
                    if (lose_evt)      cur_d = LOSE;
                    else if (win_evt)  cur_d = WIN;
                end
                WIN:   if (scr_done[2] || wdog_expired) cur_d = TITLE;
                LOSE:  if (scr_done[3] || wdog_expired) cur_d = TITLE;
                default: cur_d = TITLE;
            endcase
        end

        entering = (cur_d != cur_q);
        if (entering)      gap_d = GAP_INIT;
        else if (settled)  gap_d = 2'd0;
        else               gap_d = gap_q - 2'd1;

        wdog_d = entering ? 8'd0 : wdog_next;

        // go is registered from next-state so it rises exactly as GAP ends.
        go_d = (gap_d == 2'd0) ? screen_onehot(cur_d) : '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur_q   <= TITLE;
            gap_q   <= GAP_INIT;
            wdog_q  <= 8'd0;
            start_q <= 1'b0;
            go_q    <= '0;
        end else begin
            cur_q   <= cur_d;
            gap_q   <= gap_d;
            wdog_q  <= wdog_d;
            start_q <= start;
            go_q    <= go_d;
        end
    end

    assign go        = go_q;
    assign state_out = cur_q;

    pixel_mux4 u_pixel_mux4 (
        .clk         (clk),
        .reset_n     (reset_n),
        .sel_i       (cur_q),
        .plot_en_i   (settled),
        .src_x_i     (pix.src_x),
        .src_y_i     (pix.src_y),
        .src_color_i (pix.src_color),
        .src_plot_i  (pix.src_plot),
        .x_o         (pix.x_out),
        .y_o         (pix.y_out),
        .color_o     (pix.color_out),
        .plot_o      (pix.plot_out)
    );

endmodule

// File: tb/tb_screen_sequencer.sv
// tb/tb_screen_sequencer.sv - self-checking bench for screen_sequencer
module tb_screen_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start, frame_tick, win_evt, lose_evt;
    logic [3:0]  scr_done;
    logic [35:0] src_x;
    logic [31:0] src_y;
    logic [11:0] src_color;
    logic [3:0]  src_plot;
    logic [3:0]  go;
    logic [1:0]  state_out;

    always #5 clk = ~clk;

    screen_sequencer_if pix ();
    assign pix.src_x     = src_x;
    assign pix.src_y     = src_y;
    assign pix.src_color = src_color;
    assign pix.src_plot  = src_plot;

    screen_sequencer dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .frame_tick (frame_tick),
        .win_evt    (win_evt),
        .lose_evt   (lose_evt),
        .scr_done   (scr_done),
        .pix        (pix),
        .go         (go),
        .state_out  (state_out)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: screen number, remaining gap cycles, frames counted.
    int       m_scr, m_gap, m_wd;
    bit       m_prev;
    logic [8:0] e_x;
    logic [7:0] e_y;
    logic [2:0] e_c;
    logic       e_p;

    task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_scr = 0; m_gap = 2; m_wd = 0; m_prev = 1'b0;
        e_x = '0; e_y = '0; e_c = '0; e_p = 1'b0;
    endtask

    task automatic model_clock();
        bit settled, rise;
        int nxt;
        if (!reset_n) begin
            model_reset();
            return;
        end
        settled = (m_gap == 0);
        e_x = 9'(src_x >> (9*m_scr));
        e_y = 8'(src_y >> (8*m_scr));
        e_c = 3'(src_color >> (3*m_scr));
        e_p = settled && src_plot[m_scr];
        rise = start && !m_prev;
        m_prev = start;
        nxt = m_scr;
        if (settled) begin
            if (m_scr >= 2 && frame_tick && m_wd < 255) m_wd++;
            case (m_scr)
                0: if (rise && scr_done[0]) nxt = 1;
                1: if (lose_evt) nxt = 3; else if (win_evt) nxt = 2;
                2: if (scr_done[2] || m_wd == 255) nxt = 0;
                default: if (scr_done[3] || m_wd == 255) nxt = 0;
            endcase
        end
        if (nxt != m_scr) begin
            m_scr = nxt; m_gap = 2; m_wd = 0;
        end else if (m_gap > 0) begin
            m_gap--;
        end
    endtask

    task automatic check_all(input string tag);
        logic [3:0] e_go;
        e_go = (m_gap == 0) ? (4'b0001 << m_scr) : 4'b0000;
        chk({tag, "/state"}, 36'(state_out),     36'(m_scr));
        chk({tag, "/go"},    36'(go),            36'(e_go));
        chk({tag, "/x"},     36'(pix.x_out),     36'(e_x));
        chk({tag, "/y"},     36'(pix.y_out),     36'(e_y));
        chk({tag, "/color"}, 36'(pix.color_out), 36'(e_c));
        chk({tag, "/plot"},  36'(pix.plot_out),  36'(e_p));
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_clock();
        #1;
        check_all(tag);
    endtask

    task automatic run(input int n, input string tag);
        repeat (n) step(tag);
    endtask

    task automatic start_pulse(input string tag);
        start = 1'b1; step(tag);
        start = 1'b0; step(tag);
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; frame_tick = 1'b0; win_evt = 1'b0; lose_evt = 1'b0;
        scr_done = 4'b0; src_x = '0; src_y = '0; src_color = '0; src_plot = '0;
        model_reset();
        #1;
        check_all("reset_async");
        run(2, "reset_held");

        // Release: two GAP cycles then TITLE runs.
        reset_n = 1'b1;
        step("title_gap1");
        step("title_gap2");
        chk("go_title", 36'(go), 36'(4'b0001));

        // Start edge without done is ignored and not remembered.
        start_pulse("start_ignored");
        scr_done = 4'b0001;
        run(2, "start_not_remembered");
        chk("start_not_remembered", 36'(state_out), 36'(0));

        // Start edge with done -> PLAY.
        start = 1'b1; step("to_play");
        chk("play_state", 36'(state_out), 36'(1));
        chk("play_gap_go", 36'(go), 36'(0));
        start = 1'b0; step("play_gap");
        step("play_settle");
        chk("go_play", 36'(go), 36'(4'b0010));

        // Simultaneous win and lose -> LOSE.
        win_evt = 1'b1; lose_evt = 1'b1; step("both_evt");
        win_evt = 1'b0; lose_evt = 1'b0;
        chk("lose_priority", 36'(state_out), 36'(3));
        run(2, "lose_gap");
        chk("go_lose", 36'(go), 36'(4'b1000));

        // Watchdog: 255 frame ticks with no done returns to TITLE on the last.
        for (int i = 1; i <= 255; i++) begin
            frame_tick = 1'b1; step("wdog_tick");
            frame_tick = 1'b0;
            if (i == 254) chk("wdog_254_still_lose", 36'(state_out), 36'(3));
            if (i == 255) chk("wdog_255_title", 36'(state_out), 36'(0));
            step("wdog_idle");
        end
        step("title_settle");

        // Win event during PLAY's GAP is ignored.
        start = 1'b1; step("to_play2");
        start = 1'b0; win_evt = 1'b1; step("win_in_gap");
        win_evt = 1'b0; step("play2_settle");
        chk("gap_win_ignored", 36'(state_out), 36'(1));
        win_evt = 1'b1; step("to_win");
        win_evt = 1'b0;
        chk("win_state", 36'(state_out), 36'(2));
        run(2, "win_gap");

        // Pixel mux in WIN: only source 2 reaches the outputs.
        src_x = {4'($urandom), $urandom};
        src_y = $urandom;
        src_color = 12'($urandom);
        src_x[26:18] = 9'd100; src_y[23:16] = 8'd50; src_color[8:6] = 3'b111;
        src_plot = 4'b0100;
        step("win_pixel");
        chk("win_x", 36'(pix.x_out), 36'(100));
        chk("win_y", 36'(pix.y_out), 36'(50));
        chk("win_color", 36'(pix.color_out), 36'(7));
        chk("win_plot", 36'(pix.plot_out), 36'(1));
        src_plot = 4'b0101; step("plot0_toggle");
        src_plot = 4'b0000; step("plot2_low");
        src_plot = 4'b1011; step("others_high");

        // WIN done -> TITLE.
        scr_done = 4'b0101; step("win_done");
        scr_done = 4'b0001;
        chk("win_done_title", 36'(state_out), 36'(0));
        run(2, "title_gap3");

        // LOSE done at tick 10 returns immediately.
        start_pulse("to_play3");
        run(1, "play3_gap");
        lose_evt = 1'b1; step("to_lose");
        lose_evt = 1'b0;
        run(2, "lose2_gap");
        for (int i = 1; i <= 9; i++) begin
            frame_tick = 1'b1; step("lose_tick");
            frame_tick = 1'b0; step("lose_idle");
        end
        frame_tick = 1'b1; scr_done = 4'b1001; step("lose_done_tick10");
        frame_tick = 1'b0; scr_done = 4'b0001;
        chk("lose_done_title", 36'(state_out), 36'(0));
        run(2, "title_gap4");

        // Reset pulse mid-WIN clears everything at once.
        start_pulse("to_play4");
        run(1, "play4_gap");
        win_evt = 1'b1; step("to_win2");
        win_evt = 1'b0;
        src_plot = 4'b0100;
        run(3, "win2_run");
        reset_n = 1'b0;
        #1;
        chk("midwin_rst_go", 36'(go), 36'(0));
        chk("midwin_rst_state", 36'(state_out), 36'(0));
        chk("midwin_rst_x", 36'(pix.x_out), 36'(0));
        chk("midwin_rst_plot", 36'(pix.plot_out), 36'(0));
        model_reset();
        run(2, "midwin_rst_held");
        reset_n = 1'b1;
        run(3, "post_rst");

        // Randomized run against the model.
        for (int c = 0; c < 3000; c++) begin
            reset_n    = ($urandom_range(0, 499) != 0);
            start      = ($urandom_range(0, 3) == 0);
            frame_tick = ($urandom_range(0, 1) == 0);
            win_evt    = ($urandom_range(0, 15) == 0);
            lose_evt   = ($urandom_range(0, 15) == 0);
            scr_done   = {($urandom_range(0, 31) == 0), ($urandom_range(0, 31) == 0),
                          ($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0)};
            src_x      = {4'($urandom), $urandom};
            src_y      = $urandom;
            src_color  = 12'($urandom);
            src_plot   = 4'($urandom);
            step("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/screen_sequencer.md
SCREEN_SEQUENCER -- requirements
Module: screen_sequencer

Interface
REQ-001 clk  in  1  system clock; all state changes on its rising edge.
REQ-002 reset_n  in  1  asynchronous, active-low reset.
REQ-003 start  in  1  start key, level; sampled synchronously, rising edge detected internally.
REQ-004 frame_tick  in  1  one-cycle 60 Hz frame pulse (the same pulse the screens receive as sixty_signal).
REQ-005 win_evt, lose_evt  in  1 each  one-cycle game-result pulses from play logic.
REQ-006 scr_done  in  4  per-screen done; bit 0 TITLE, 1 PLAY, 2 WIN, 3 LOSE.
REQ-007 src_x  in  36  four packed 9-bit x; screen k occupies bits [9k+8:9k].
REQ-008 src_y  in  32  four packed 8-bit y; screen k occupies bits [8k+7:8k].
REQ-009 src_color  in  12  four packed 3-bit colors; screen k occupies bits [3k+2:3k].
REQ-010 src_plot  in  4  per-screen plot strobe.
REQ-011 go  out  4  one-hot level "run" to the screens; bit k is high while screen k is active and settled.
REQ-012 x_out  out  9, y_out  out  8, color_out  out  3, plot_out  out  1  registered pixel stream to the VGA adapter.
REQ-013 state_out  out  2  current screen index: 0 TITLE, 1 PLAY, 2 WIN, 3 LOSE.

Function
REQ-014 FSM: cur screen (2 bits) plus a GAP phase; GAP lasts exactly 2 clk cycles on every screen entry, with go = 0 and plot_out = 0.
REQ-015 After GAP, go drives one-hot bit cur; it stays high until the next transition.
REQ-016 TITLE -> PLAY on a start rising edge while scr_done[0] = 1; a start edge while scr_done[0] = 0 is ignored and not remembered.
REQ-017 PLAY -> WIN on win_evt; PLAY -> LOSE on lose_evt; if both are high in the same cycle, LOSE wins.
REQ-018 WIN -> TITLE on scr_done[2]; LOSE -> TITLE on scr_done[3].
REQ-019 Events arriving during GAP are ignored; transitions are evaluated only in settled (non-GAP) cycles.
REQ-020 Watchdog: an 8-bit frame counter clears on screen entry and increments on frame_tick in settled WIN/LOSE cycles.
REQ-021 The watchdog saturates at 255; reaching 255 forces a transition to TITLE even if no done arrives.
REQ-022 The watchdog is inactive in TITLE and PLAY.
REQ-023 Pixel mux: each cycle, x_out/y_out/color_out register the fields of source cur, and plot_out registers src_plot[cur] AND settled.
REQ-024 Mux latency is 1 cycle; non-selected sources never reach the outputs.
REQ-025 state_out changes in the same cycle that GAP begins.

Reset
REQ-026 While reset_n = 0: cur = TITLE, GAP counter = 2, go = 0, x_out = y_out = color_out = 0, plot_out = 0, watchdog = 0, start edge register = 0.
REQ-027 After release, TITLE follows the normal entry sequence: 2 GAP cycles, then go = 4'b0001.
REQ-028 Reset asserted mid-screen or mid-GAP takes effect immediately, with no completion of the pending transition.

Structure
REQ-029 A shared package holds the screen index constants (TITLE/PLAY/WIN/LOSE), GAP_CYCLES = 2, WDOG_MAX = 255 and the field widths 9/8/3.
REQ-030 The pixel mux is one sub-module, pixel_mux4: registered, 4:1, with a plot gate input; the FSM and watchdog stay in the top level.

Verification
REQ-031 Reset, then release -> go = 0 for 2 cycles, then go = 0001 and state_out = 0; all pixel outputs stay 0 until then.
REQ-032 scr_done[0] = 1, start pulse -> state_out = 1 next cycle, go = 0 for 2 cycles, then go = 0010; a start pulse with scr_done[0] = 0 -> no change.
REQ-033 In PLAY, win_evt and lose_evt high in the same cycle -> state_out = 3, go = 1000 after GAP.
REQ-034 In WIN, src_x[26:18] = 100, src_y[23:16] = 50, src_color[8:6] = 3'b111, src_plot[2] = 1 -> one cycle later x_out = 100, y_out = 50, color_out = 7, plot_out = 1; src_plot[0] toggling has no effect.
REQ-035 In LOSE, no scr_done and 255 frame_ticks -> return to TITLE on the 255th tick; scr_done[3] at tick 10 -> return to TITLE at that cycle.
REQ-036 win_evt during a GAP cycle -> ignored; reset pulse mid-WIN -> go = 0 and outputs = 0 immediately.
